// File: rtl/core_pkg.sv
// core_pkg: shared datapath widths and write-back control bit positions for the core.
package core_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W = 5;
    localparam int WB_W = 2;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
endpackage

// File: rtl/pipe_reg_en.sv
// pipe_reg_en: W-bit register with load enable and asynchronous active-low clear.
module pipe_reg_en #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            q <= '0;
        else if (en)
            q <= d;
endmodule

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM->WB pipeline register; one enabled flop bank per field, all
// sharing one enable so every field updates on the same edge.
module mem_wb_pipe_reg
    import core_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W,
    parameter int BW = WB_W
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          startin,
    input  logic [DW-1:0] read_data_input,
    input  logic [DW-1:0] alu_result_input,
    input  logic [RW-1:0] write_register_input,
    input  logic [BW-1:0] WB_input,
    output logic [DW-1:0] read_data_output,
    output logic [DW-1:0] alu_result_output,
    output logic [RW-1:0] write_register_output,
    output logic [BW-1:0] WB_output
);
    pipe_reg_en #(.W(DW)) u_read_data (
        .clock(clock), .reset_n(reset_n), .en(startin),
        .d(read_data_input), .q(read_data_output)
    );
    pipe_reg_en #(.W(DW)) u_alu_result (
        .clock(clock), .reset_n(reset_n), .en(startin),
        .d(alu_result_input), .q(alu_result_output)
    );
    pipe_reg_en #(.W(RW)) u_write_register (
        .clock(clock), .reset_n(reset_n), .en(startin),
        .d(write_register_input), .q(write_register_output)
    );
    pipe_reg_en #(.W(BW)) u_wb (
        .clock(clock), .reset_n(reset_n), .en(startin),
        .d(WB_input), .q(WB_output)
    );
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: directed checks of load, hold, async reset and back-to-back capture.
module tb_mem_wb_pipe_reg;
    import core_pkg::*;
    localparam int VW = 2 * DATA_W + REG_W + WB_W;
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic startin = 1'b0;
    logic [DATA_W-1:0] rd_in = '0, alu_in = '0, rd_out, alu_out;
    logic [REG_W-1:0] wr_in = '0, wr_out;
    logic [WB_W-1:0] wb_in = '0, wb_out;
    logic [VW-1:0] got, prev;
    int pass_cnt = 0;
    int total = 0;

    mem_wb_pipe_reg dut (
        .clock(clock), .reset_n(reset_n), .startin(startin),
        .read_data_input(rd_in), .alu_result_input(alu_in),
        .write_register_input(wr_in), .WB_input(wb_in),
        .read_data_output(rd_out), .alu_result_output(alu_out),
        .write_register_output(wr_out), .WB_output(wb_out)
    );

    always #5 clock = ~clock;
    assign got = {rd_out, alu_out, wr_out, wb_out};

    task automatic drive(input logic [VW-1:0] v);
        {rd_in, alu_in, wr_in, wb_in} = v;
    endtask

    task automatic test_reset;
        #1;
        reset_n = 1'b0;
        startin = 1'b1;
        drive({$urandom, $urandom, 5'($urandom), 2'($urandom)});
        #7;
        total++;
        if (got !== '0) $display("FAIL reset_hold got=%h exp=%h", got, {VW{1'b0}});
        else pass_cnt++;
        reset_n = 1'b1;
        startin = 1'b0;
        #3;
        total++;
        if (got !== '0) $display("FAIL reset_release got=%h exp=%h", got, {VW{1'b0}});
        else pass_cnt++;
    endtask

    task automatic test_load;
        drive({32'hA5A5A5A5, 32'h5A5A5A5A, 5'h1F, 2'b10});
        startin = 1'b1;
        #5;
        total++;
        if (got !== {32'hA5A5A5A5, 32'h5A5A5A5A, 5'h1F, 2'b10})
            $display("FAIL load got=%h exp=%h", got, {32'hA5A5A5A5, 32'h5A5A5A5A, 5'h1F, 2'b10});
        else pass_cnt++;
        total++;
        if (wb_out[WB_REGWRITE] !== 1'b1 || wb_out[WB_MEMTOREG] !== 1'b0)
            $display("FAIL load_wb_bits got=%b exp=10", wb_out);
        else pass_cnt++;
        startin = 1'b0;
    endtask

    task automatic test_hold;
        #14;
        drive({32'h12345678, 32'h87654321, 5'h0F, 2'b01});
        #6;
        total++;
        if (got !== {32'hA5A5A5A5, 32'h5A5A5A5A, 5'h1F, 2'b10})
            $display("FAIL hold_1 got=%h exp=%h", got, {32'hA5A5A5A5, 32'h5A5A5A5A, 5'h1F, 2'b10});
        else pass_cnt++;
        #4;
        drive({32'hFFFFFFFF, 32'h11111111, 5'h0A, 2'b11});
        #6;
        total++;
        if (got !== {32'hA5A5A5A5, 32'h5A5A5A5A, 5'h1F, 2'b10})
            $display("FAIL hold_2 got=%h exp=%h", got, {32'hA5A5A5A5, 32'h5A5A5A5A, 5'h1F, 2'b10});
        else pass_cnt++;
    endtask

    task automatic test_reload;
        #4;
        startin = 1'b1;
        #6;
        total++;
        if (got !== {32'hFFFFFFFF, 32'h11111111, 5'h0A, 2'b11})
            $display("FAIL reload got=%h exp=%h", got, {32'hFFFFFFFF, 32'h11111111, 5'h0A, 2'b11});
        else pass_cnt++;
        startin = 1'b0;
    endtask

    task automatic test_async_reset;
        #2;
        reset_n = 1'b0;
        startin = 1'b1;
        #1;
        total++;
        if (got !== '0) $display("FAIL async_reset got=%h exp=%h", got, {VW{1'b0}});
        else pass_cnt++;
        #7;
        total++;
        if (got !== '0) $display("FAIL reset_beats_load got=%h exp=%h", got, {VW{1'b0}});
        else pass_cnt++;
        reset_n = 1'b1;
        startin = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [VW-1:0] vec [3];
        vec[0] = {32'hDEADBEEF, 32'h00000001, 5'h03, 2'b10};
        vec[1] = {32'hCAFEF00D, 32'h80000000, 5'h11, 2'b01};
        vec[2] = {32'h0BADC0DE, 32'h7FFFFFFF, 5'h1E, 2'b11};
        prev = '0;
        #4;
        startin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(vec[i]);
            #3;
            total++;
            if (got !== prev) $display("FAIL b2b_pre_%0d got=%h exp=%h", i, got, prev);
            else pass_cnt++;
            #3;
            total++;
            if (got !== vec[i]) $display("FAIL b2b_post_%0d got=%h exp=%h", i, got, vec[i]);
            else pass_cnt++;
            prev = vec[i];
            #4;
        end
        startin = 1'b0;
        drive({VW{1'bx}});
        #10;
        total++;
        if (got !== vec[2]) $display("FAIL hold_x_inputs got=%h exp=%h", got, vec[2]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_load;
        test_hold;
        test_reload;
        test_async_reset;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
